// File: rtl/frame_capture.sv
// Frame-store controller: captures one active frame as RGB332 into BRAM,
// then drives read addresses so the stored frame plays back on the BRAM output.
module frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              store_bram,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [23:0]       pixel_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [7:0]        bram_din,
  output logic [1:0]        bram_state,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  localparam logic [10:0]       H_LIM      = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM      = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] PIX_TOTAL  = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] pix_cnt;
  logic              store_q;
  logic              store_rise;
  logic              in_act;
  logic              vblank;
  logic              last_write;

  assign in_act     = (hcount < H_LIM) && (vcount < V_LIM);
  assign vblank     = (vcount >= V_LIM);
  assign store_rise = store_bram && !store_q;

  // Running raster index; vblank re-zeroes it so (0,0) always maps to address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= '0;
    end else if (vblank) begin
      pix_cnt <= '0;
    end else if (in_act && (pix_cnt != PIX_TOTAL)) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BRAM_IDLE;
      store_q    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      store_q    <= store_bram;
      frame_done <= last_write;
    end
  end

  always_comb begin
    bram_we    = 1'b0;
    last_write = 1'b0;
    state_n    = state;
    unique case (state)
      BRAM_IDLE: begin
        if (store_rise) state_n = CAPTURE_FRAME;
      end
      CAPTURE_FRAME: begin
        if (!store_bram)  state_n = BRAM_IDLE;
        else if (vblank)  state_n = WRITING_FRAME;
      end
      WRITING_FRAME: begin
        bram_we    = in_act;
        last_write = in_act && (pix_cnt == PIX_LAST);
        // Completing the final write wins over a simultaneous release.
        if (last_write)       state_n = READING_FRAME;
        else if (!store_bram) state_n = BRAM_IDLE;
      end
      READING_FRAME: begin
        if (!store_bram) state_n = BRAM_IDLE;
      end
      default: state_n = BRAM_IDLE;
    endcase
  end

  assign bram_addr  = pix_cnt;
  assign bram_din   = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};
  assign bram_state = state;

  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{pixel_in[20:16], pixel_in[12:8], pixel_in[5:0]};

endmodule
